// File: rtl/data_mem_responder_if.sv
// Request/response bus between a core (master) and the data memory responder (slave).
// One request in flight at a time; the response holds until the core takes it.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_ready;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed request-to-response latency and
// error flagging for misaligned or out-of-range byte addresses.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = 4;
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              we_reg;
  logic [31:0]       addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       mem_rdata_reg;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              op_we;
  logic [31:0]       op_addr;
  logic [31:0]       op_wdata;
  logic              op_err;
  logic              cap_err;
  logic              mem_wr;

  assign accept = (state_reg == IDLE) && bus.req_valid;

  // With LATENCY=1 the memory access happens on the acceptance edge itself,
  // so the operands come straight from the bus while the registers capture them.
  assign op_we    = (state_reg == IDLE) ? bus.req_we    : we_reg;
  assign op_addr  = (state_reg == IDLE) ? bus.req_addr  : addr_reg;
  assign op_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;
  assign op_err   = (op_addr[1:0] != 2'b00) || (op_addr >= MEM_BYTES);
  assign cap_err  = (addr_reg[1:0] != 2'b00) || (addr_reg >= MEM_BYTES);

  assign enter_resp = (state_reg != RESP) && (state_next == RESP);
  assign mem_wr     = enter_resp && op_we && !op_err && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= bus.req_we;
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            cnt_next   = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == '0) state_next = RESP;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      RESP: begin
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage is not reset; the read register only loads on the edge entering
  // RESP, which keeps resp_rdata stable for the whole response.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[op_addr[AW+1:2]] <= op_wdata;
    if (enter_resp) mem_rdata_reg <= mem[op_addr[AW+1:2]];
  end

  always_comb begin
    bus.req_ready  = (state_reg == IDLE);
    bus.resp_valid = (state_reg == RESP);
    bus.resp_err   = (state_reg == RESP) && cap_err;
    bus.resp_rdata = ((state_reg == RESP) && !cap_err && !we_reg) ? mem_rdata_reg : 32'h0;
  end

endmodule
